// File: rtl/io_to_axi.sv
// io_to_axi: bridge from a single-outstanding IO bus to a valid/ready
// request channel with a pulsed response channel.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   io_addr_strobe       IO transfer start pulse
//   io_read_strobe       read qualifier, valid with io_addr_strobe
//   io_write_strobe      write qualifier, valid with io_addr_strobe
//   io_addr              byte address (bits [1:0] ignored)
//   io_byte_enable       write byte lanes
//   io_write_data        write data
//   io_read_data         response data, nonzero only while io_ready=1
//   io_ready             one-cycle transfer-complete pulse
//   avalid / aready      request handshake toward the target
//   awe, aaddr           request direction (1=write) and word address
//   adata, astrb         write data and byte strobes
//   bvalid, bdata        response pulse and data from the target
//   timeout              one-cycle pulse when a transfer is aborted
//
// TIMEOUT_CYCLES bounds the cycles spent in REQ/RESP; 0 disables it.
module io_to_axi #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_addr,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        avalid,
  input  logic        aready,
  output logic        awe,
  output logic [29:0] aaddr,
  output logic [31:0] adata,
  output logic [3:0]  astrb,
  input  logic        bvalid,
  input  logic [31:0] bdata,
  output logic        timeout
);

  // A zero-width counter is illegal, so keep one bit when the timeout is off.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             avalid_q;
  logic             awe_q;
  logic [29:0]      aaddr_q;
  logic [31:0]      adata_q;
  logic [3:0]       astrb_q;
  logic             io_ready_q;
  logic [31:0]      io_read_data_q;
  logic             timeout_q;
  logic             tmo_hit;
  logic             start;

  // Byte offset within the word is not forwarded to the target.
  logic unused_addr_bits;
  assign unused_addr_bits = ^io_addr[1:0];

  assign start = io_addr_strobe && (io_read_strobe || io_write_strobe);

  // Saturating increment of the busy-cycle counter.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Abort in the cycle whose increment would make the counter reach the limit,
  // so the request is visible for exactly TIMEOUT_CYCLES cycles.
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      avalid_q       <= 1'b0;
      awe_q          <= 1'b0;
      aaddr_q        <= '0;
      adata_q        <= '0;
      astrb_q        <= '0;
      io_ready_q     <= 1'b0;
      io_read_data_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses.
      io_ready_q     <= 1'b0;
      io_read_data_q <= '0;
      timeout_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            // A write strobe wins when both qualifiers are set.
            awe_q    <= io_write_strobe;
            aaddr_q  <= io_addr[31:2];
            adata_q  <= io_write_data;
            astrb_q  <= io_byte_enable;
            cnt_q    <= '0;
            avalid_q <= 1'b1;
            state_q  <= REQ;
          end
        end

        REQ: begin
          cnt_q <= cnt_d;
          if (aready && bvalid) begin
            // Completion beats a coincident timeout.
            state_q        <= IDLE;
            avalid_q       <= 1'b0;
            io_ready_q     <= 1'b1;
            io_read_data_q <= awe_q ? 32'h0 : bdata;
          end else if (tmo_hit) begin
            state_q        <= IDLE;
            avalid_q       <= 1'b0;
            io_ready_q     <= 1'b1;
            io_read_data_q <= 32'hFFFF_FFFF;
            timeout_q      <= 1'b1;
          end else if (aready) begin
            state_q  <= RESP;
            avalid_q <= 1'b0;
          end
        end

        RESP: begin
          cnt_q <= cnt_d;
          if (bvalid) begin
            state_q        <= IDLE;
            io_ready_q     <= 1'b1;
            io_read_data_q <= awe_q ? 32'h0 : bdata;
          end else if (tmo_hit) begin
            state_q        <= IDLE;
            io_ready_q     <= 1'b1;
            io_read_data_q <= 32'hFFFF_FFFF;
            timeout_q      <= 1'b1;
          end
        end

        default: begin
          state_q  <= IDLE;
          avalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign avalid       = avalid_q;
  assign awe          = awe_q;
  assign aaddr        = aaddr_q;
  assign adata        = adata_q;
  assign astrb        = astrb_q;
  assign io_ready     = io_ready_q;
  assign io_read_data = io_read_data_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_io_to_axi.sv
module tb_io_to_axi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_addr;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic        avalid;
  logic        aready;
  logic        awe;
  logic [29:0] aaddr;
  logic [31:0] adata;
  logic [3:0]  astrb;
  logic        bvalid;
  logic [31:0] bdata;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  io_to_axi #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .io_addr_strobe  (io_addr_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_write_strobe (io_write_strobe),
    .io_addr         (io_addr),
    .io_byte_enable  (io_byte_enable),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .io_ready        (io_ready),
    .avalid          (avalid),
    .aready          (aready),
    .awe             (awe),
    .aaddr           (aaddr),
    .adata           (adata),
    .astrb           (astrb),
    .bvalid          (bvalid),
    .bdata           (bdata),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  // One row = inputs driven during a cycle and the registered outputs seen in it.
  typedef struct {
    logic        stb;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ardy;
    logic        bv;
    logic [31:0] bd;
    logic        e_avalid;
    logic        e_awe;
    logic [29:0] e_aaddr;
    logic [31:0] e_adata;
    logic [3:0]  e_astrb;
    logic        e_rdy;
    logic [31:0] e_rdata;
    logic        e_to;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    io_addr         = 32'h0;
    io_byte_enable  = 4'h0;
    io_write_data   = 32'h0;
    aready          = 1'b0;
    bvalid          = 1'b0;
    bdata           = 32'h0;
  endtask

  task automatic strobe(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_addr         = a;
    io_byte_enable  = be;
    io_write_data   = wd;
  endtask

  initial begin
    int n;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    //        stb  rd   wr   addr          be    wdata         ardy bv   bdata        avl  awe  aaddr         adata         astrb rdy  rdata         to
    // reset state
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b0,30'h0,        32'h0,       4'h0,1'b0,32'h0,       1'b0});
    // minimum-latency read
    vq.push_back('{1'b1,1'b1,1'b0,32'hC0000010,4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b0,30'h0,        32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b1,1'b1,32'h12345678,1'b1,1'b0,30'h30000004,32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b0,30'h30000004,32'h0,       4'h0,1'b1,32'h12345678,1'b0});
    // write with aready held low 3 cycles, bvalid 2 cycles after acceptance
    vq.push_back('{1'b1,1'b0,1'b1,32'h00000100,4'h3,32'hA5A5A5A5,1'b0,1'b0,32'h0,       1'b0,1'b0,30'h30000004,32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b1,1'b1,30'h40,       32'hA5A5A5A5,4'h3,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b1,1'b1,30'h40,       32'hA5A5A5A5,4'h3,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b1,1'b1,30'h40,       32'hA5A5A5A5,4'h3,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b1,1'b0,32'h0,       1'b1,1'b1,30'h40,       32'hA5A5A5A5,4'h3,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b1,30'h40,       32'hA5A5A5A5,4'h3,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b1,32'hDEADBEEF,1'b0,1'b1,30'h40,       32'hA5A5A5A5,4'h3,1'b0,32'h0,       1'b0});
    // io_ready cycle of the write, new read strobe accepted back-to-back
    vq.push_back('{1'b1,1'b1,1'b0,32'h00000200,4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b1,30'h40,       32'hA5A5A5A5,4'h3,1'b1,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b1,1'b1,32'h11112222,1'b1,1'b0,30'h80,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b0,30'h80,       32'h0,       4'h0,1'b1,32'h11112222,1'b0});
    // second strobe while in RESP is ignored
    vq.push_back('{1'b1,1'b1,1'b0,32'h00000300,4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b0,30'h80,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b1,1'b0,32'h0,       1'b1,1'b0,30'hC0,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b1,1'b0,1'b1,32'h00000400,4'hF,32'hFFFFFFFF,1'b0,1'b0,32'h0,       1'b0,1'b0,30'hC0,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b1,32'h00000055,1'b0,1'b0,30'hC0,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b0,30'hC0,       32'h0,       4'h0,1'b1,32'h00000055,1'b0});
    // stray bvalid in IDLE ignored
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b1,32'h00000077,1'b0,1'b0,30'hC0,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b0,30'hC0,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    // both qualifiers -> write
    vq.push_back('{1'b1,1'b1,1'b1,32'h00000010,4'hF,32'h00000012,1'b0,1'b0,32'h0,       1'b0,1'b0,30'hC0,       32'h0,       4'h0,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b1,1'b1,32'h00000099,1'b1,1'b1,30'h4,        32'h00000012,4'hF,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b1,30'h4,        32'h00000012,4'hF,1'b1,32'h0,       1'b0});
    // strobe with no qualifier ignored
    vq.push_back('{1'b1,1'b0,1'b0,32'h00000020,4'hF,32'h00000034,1'b0,1'b0,32'h0,       1'b0,1'b1,30'h4,        32'h00000012,4'hF,1'b0,32'h0,       1'b0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0,       4'h0,32'h0,       1'b0,1'b0,32'h0,       1'b0,1'b1,30'h4,        32'h00000012,4'hF,1'b0,32'h0,       1'b0});

    foreach (vq[i]) begin
      io_addr_strobe  = vq[i].stb;
      io_read_strobe  = vq[i].rd;
      io_write_strobe = vq[i].wr;
      io_addr         = vq[i].addr;
      io_byte_enable  = vq[i].be;
      io_write_data   = vq[i].wdata;
      aready          = vq[i].ardy;
      bvalid          = vq[i].bv;
      bdata           = vq[i].bd;
      chk($sformatf("v%0d.avalid", i),   {31'h0, avalid},   {31'h0, vq[i].e_avalid});
      chk($sformatf("v%0d.awe", i),      {31'h0, awe},      {31'h0, vq[i].e_awe});
      chk($sformatf("v%0d.aaddr", i),    {2'b0, aaddr},     {2'b0, vq[i].e_aaddr});
      chk($sformatf("v%0d.adata", i),    adata,             vq[i].e_adata);
      chk($sformatf("v%0d.astrb", i),    {28'h0, astrb},    {28'h0, vq[i].e_astrb});
      chk($sformatf("v%0d.io_ready", i), {31'h0, io_ready}, {31'h0, vq[i].e_rdy});
      chk($sformatf("v%0d.rdata", i),    io_read_data,      vq[i].e_rdata);
      chk($sformatf("v%0d.timeout", i),  {31'h0, timeout},  {31'h0, vq[i].e_to});
      $display("vec %0d: avalid=%0b aaddr=%08h io_ready=%0b rdata=%08h timeout=%0b",
               i, avalid, aaddr, io_ready, io_read_data, timeout);
      tick();
    end
    idle_in();

    // Timeout with aready stuck low: avalid for 8 cycles, then abort pulse.
    strobe(1'b1, 1'b0, 32'h00000500, 4'h0, 32'h0);
    tick();
    idle_in();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!avalid) break;
      n++;
      tick();
    end
    chk("tmo.avalid_cycles", n, 8);
    chk("tmo.io_ready", {31'h0, io_ready}, 32'h1);
    chk("tmo.timeout", {31'h0, timeout}, 32'h1);
    chk("tmo.rdata", io_read_data, 32'hFFFFFFFF);
    $display("timeout: avalid cycles=%0d io_ready=%0b timeout=%0b rdata=%08h",
             n, io_ready, timeout, io_read_data);
    tick();
    chk("tmo.pulse_end_ready", {31'h0, io_ready}, 32'h0);
    chk("tmo.pulse_end_to", {31'h0, timeout}, 32'h0);
    bvalid = 1'b1;
    bdata  = 32'h0000ABCD;
    tick();
    bvalid = 1'b0;
    tick();
    chk("tmo.late_bvalid", {31'h0, io_ready}, 32'h0);
    $display("late bvalid after timeout: io_ready=%0b", io_ready);

    // Completion in the same cycle the counter would expire wins.
    strobe(1'b1, 1'b0, 32'h00000600, 4'h0, 32'h0);
    tick();
    idle_in();
    for (int i = 0; i < 7; i++) tick();
    chk("prio.avalid", {31'h0, avalid}, 32'h1);
    aready = 1'b1;
    bvalid = 1'b1;
    bdata  = 32'h00000099;
    tick();
    idle_in();
    chk("prio.io_ready", {31'h0, io_ready}, 32'h1);
    chk("prio.rdata", io_read_data, 32'h00000099);
    chk("prio.timeout", {31'h0, timeout}, 32'h0);
    $display("priority: io_ready=%0b rdata=%08h timeout=%0b", io_ready, io_read_data, timeout);
    tick();

    // Reset while in REQ: avalid drops without waiting for a clock.
    strobe(1'b1, 1'b0, 32'h00000680, 4'h0, 32'h0);
    tick();
    idle_in();
    chk("rstreq.avalid_before", {31'h0, avalid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstreq.avalid", {31'h0, avalid}, 32'h0);
    $display("reset in REQ: avalid=%0b", avalid);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset while in RESP: transfer abandoned, no io_ready, next read normal.
    strobe(1'b1, 1'b0, 32'h00000700, 4'h0, 32'h0);
    tick();
    idle_in();
    aready = 1'b1;
    tick();
    aready = 1'b0;
    chk("rstresp.aaddr_before", {2'b0, aaddr}, 32'h1C0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstresp.avalid", {31'h0, avalid}, 32'h0);
    chk("rstresp.aaddr", {2'b0, aaddr}, 32'h0);
    chk("rstresp.io_ready", {31'h0, io_ready}, 32'h0);
    $display("reset in RESP: avalid=%0b aaddr=%08h io_ready=%0b", avalid, aaddr, io_ready);
    @(negedge clk);
    rst_n  = 1'b1;
    bvalid = 1'b1;
    bdata  = 32'h00001234;
    tick();
    bvalid = 1'b0;
    tick();
    chk("rstresp.no_ready", {31'h0, io_ready}, 32'h0);
    strobe(1'b1, 1'b0, 32'h00000800, 4'h0, 32'h0);
    chk("post.avalid_c0", {31'h0, avalid}, 32'h0);
    tick();
    idle_in();
    aready = 1'b1;
    bvalid = 1'b1;
    bdata  = 32'h0000CAFE;
    chk("post.avalid_c1", {31'h0, avalid}, 32'h1);
    chk("post.aaddr", {2'b0, aaddr}, 32'h200);
    tick();
    idle_in();
    chk("post.io_ready", {31'h0, io_ready}, 32'h1);
    chk("post.rdata", io_read_data, 32'h0000CAFE);
    $display("read after reset: io_ready=%0b rdata=%08h", io_ready, io_read_data);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
